// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: the store-data port from the encoder, the load
// hazard query, the data-memory write port and the occupancy status.
interface store_buffer_if #(
  parameter int AW    = 30,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;

  logic [AW-1:0] ld_addr;
  logic [3:0]    ld_be;
  logic          ld_hazard;

  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [3:0]    mem_be;

  logic [CW-1:0] count;
  logic          empty;

  // The buffer itself sits on the slave side of this bundle.
  modport slave (
    input  st_valid, st_addr, st_data, st_be,
    input  ld_addr, ld_be,
    input  mem_ack,
    output st_ready, ld_hazard,
    output mem_req, mem_addr, mem_data, mem_be,
    output count, empty
  );

  // The encoder, load path and memory model drive the master side.
  modport master (
    output st_valid, st_addr, st_data, st_be,
    output ld_addr, ld_be,
    output mem_ack,
    input  st_ready, ld_hazard,
    input  mem_req, mem_addr, mem_data, mem_be,
    input  count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: circular queue of pending word stores with merge into the
// youngest entry, a two-state drain engine toward data memory, and a load
// hazard flag covering every valid entry including the one in flight.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_be   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [0:0]       r_state;

  logic             r_mem_req;
  logic [AW-1:0]    r_mem_addr;
  logic [31:0]      r_mem_data;
  logic [3:0]       r_mem_be;

  logic             w_st_ready;
  logic             w_accept;
  logic             w_merge;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_youngest;
  logic [31:0]      w_merge_data;
  logic [3:0]       w_merge_be;
  logic             w_hazard;
  logic             w_issue_from_merge;

  // Readiness comes from the registered count only, so a full buffer cannot
  // take a store on the same edge that the head is popped.
  assign w_st_ready = (r_count < CW'(DEPTH));
  assign w_accept   = bus.st_valid && w_st_ready;
  assign w_youngest = r_tail - PW'(1);
  assign w_pop      = (r_state == ISSUE) && bus.mem_ack;

  // The youngest entry is mergeable unless it is the one currently on the bus.
  assign w_merge = w_accept && (bus.st_be != 4'b0000) && (r_count != '0) &&
                   (r_addr[w_youngest] == bus.st_addr) &&
                   ((r_state != ISSUE) || (r_count > CW'(1)));
  assign w_push  = w_accept && (bus.st_be != 4'b0000) && !w_merge;

  // If the drain engine launches the head on the same edge that a merge
  // updates it, the launched copy must already contain the merged bytes.
  assign w_issue_from_merge = w_merge && (w_youngest == r_head);

  // Byte-lane merge of the incoming store over the youngest entry; lane 0 is
  // the most significant byte.
  always_comb begin
    w_merge_data = r_data[w_youngest];
    for (int i = 0; i < 4; i++) begin
      if (bus.st_be[i]) begin
        w_merge_data[31-8*i -: 8] = bus.st_data[31-8*i -: 8];
      end
    end
    w_merge_be = r_be[w_youngest] | bus.st_be;
  end

  // A load is hazardous when any valid entry hits its word with overlapping lanes.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == bus.ld_addr) && ((r_be[i] & bus.ld_be) != 4'b0000)) begin
        w_hazard = 1'b1;
      end
    end
  end

  // Queue storage: pop at head, push or merge at tail, occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_addr[r_tail]  <= bus.st_addr;
        r_data[r_tail]  <= bus.st_data;
        r_be[r_tail]    <= bus.st_be;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_merge) begin
        r_data[w_youngest] <= w_merge_data;
        r_be[w_youngest]   <= w_merge_be;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Drain engine: launch the head when idle, hold the bus until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_be   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_mem_addr <= r_addr[r_head];
            r_mem_data <= w_issue_from_merge ? w_merge_data : r_data[r_head];
            r_mem_be   <= w_issue_from_merge ? w_merge_be   : r_be[r_head];
            r_mem_req  <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.st_ready  = w_st_ready;
  assign bus.ld_hazard = w_hazard;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_be    = r_mem_be;
  assign bus.count     = r_count;
  assign bus.empty     = (r_count == '0);

endmodule
